// File: rtl/shift_mac_seq.sv
// Sequential signed shift-and-add multiply-accumulate: one coefficient bit per clock,
// a single shared adder, optional accumulation into the held result.
//
// state | meaning
// IDLE  | waiting for start; acc_out holds last result
// RUN   | processing coefficient bit k (0 .. H_W-1)
// DONE  | one-cycle result strobe (out_valid)
module shift_mac_seq #(
    parameter int IN_W  = 4,
    parameter int H_W   = 9,
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    acc_en,
    input  logic                    clr,
    input  logic [IN_W-1:0]         in_x,
    input  logic [H_W-1:0]          h,
    output logic                    busy,
    output logic                    out_valid,
    output logic [ACC_W-1:0]        acc_out
);

    localparam int K_W = (H_W > 1) ? $clog2(H_W) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(H_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [H_W-1:0]     h_reg, h_nxt;
    logic [ACC_W-1:0]   x_reg, x_nxt;
    logic [ACC_W-1:0]   partial, partial_nxt;
    logic [ACC_W-1:0]   acc_nxt;
    logic [K_W-1:0]     k, k_nxt;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            h_reg   <= '0;
            x_reg   <= '0;
            partial <= '0;
            acc_out <= '0;
            k       <= '0;
        end else begin
            state   <= state_nxt;
            h_reg   <= h_nxt;
            x_reg   <= x_nxt;
            partial <= partial_nxt;
            acc_out <= acc_nxt;
            k       <= k_nxt;
        end
    end

    // The coefficient MSB has negative weight, so the last bit subtracts.
    assign addend = h_reg[k] ? x_reg : '0;
    assign sum    = (k == K_LAST) ? (partial - addend) : (partial + addend);

    always_comb begin
        state_nxt   = state;
        h_nxt       = h_reg;
        x_nxt       = x_reg;
        partial_nxt = partial;
        acc_nxt     = acc_out;
        k_nxt       = k;
        if (clr) begin
            state_nxt   = IDLE;
            partial_nxt = '0;
            acc_nxt     = '0;
            k_nxt       = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        h_nxt       = h;
                        x_nxt       = {{(ACC_W-IN_W){in_x[IN_W-1]}}, in_x};
                        partial_nxt = acc_en ? acc_out : '0;
                        k_nxt       = '0;
                        state_nxt   = RUN;
                    end
                end
                RUN: begin
                    partial_nxt = sum;
                    x_nxt       = {x_reg[ACC_W-2:0], 1'b0};
                    if (k == K_LAST) begin
                        acc_nxt   = sum;
                        k_nxt     = '0;
                        state_nxt = DONE;
                    end else begin
                        k_nxt = k + 1'b1;
                    end
                end
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_shift_mac_seq.sv
// Self-checking bench for shift_mac_seq: directed cases plus random operands,
// compared against an integer-arithmetic MAC model.
module tb_shift_mac_seq;

    localparam int IN_W  = 4;
    localparam int H_W   = 9;
    localparam int ACC_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, acc_en, clr;
    logic [IN_W-1:0]    in_x;
    logic [H_W-1:0]     h;
    logic               busy, out_valid;
    logic [ACC_W-1:0]   acc_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [ACC_W-1:0] model_acc;

    shift_mac_seq #(.IN_W(IN_W), .H_W(H_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_en(acc_en), .clr(clr),
        .in_x(in_x), .h(h), .busy(busy), .out_valid(out_valid), .acc_out(acc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full operation: drive start, watch busy/out_valid, compare against model.
    task automatic run_op(input logic [IN_W-1:0] xv, input logic [H_W-1:0] hv,
                          input logic ae, input bit spam);
        int prod;
        int busy_cnt;
        int v_cnt;
        int lat;
        logic [ACC_W-1:0] exp;
        prod = int'($signed(xv)) * int'($signed(hv));
        exp  = ae ? model_acc + ACC_W'(prod) : ACC_W'(prod);
        @(negedge clk);
        in_x = xv; h = hv; acc_en = ae; start = 1'b1;
        @(posedge clk); #1;
        busy_cnt = busy ? 1 : 0;
        v_cnt = 0;
        lat = -1;
        for (int i = 1; i <= H_W + 3; i++) begin
            @(negedge clk);
            if (spam && busy) begin
                start  = 1'b1;
                in_x   = IN_W'($urandom);
                h      = H_W'($urandom);
                acc_en = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (out_valid) begin
                v_cnt++;
                lat = i;
                check("result_at_valid", 32'(acc_out), 32'(exp));
            end
        end
        start = 1'b0;
        check("latency", lat, H_W);
        check("valid_pulses", v_cnt, 1);
        check("busy_cycles", busy_cnt, H_W + 1);
        check("acc_held", 32'(acc_out), 32'(exp));
        model_acc = exp;
    endtask

    initial begin
        int nv;
        rst_n = 1'b0; start = 1'b0; acc_en = 1'b0; clr = 1'b0;
        in_x = '0; h = '0;
        model_acc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_acc", 32'(acc_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'hD, 9'd5, 1'b0, 1'b0);
        check("neg3x5", 32'(acc_out), 32'h0000_FFF1);
        run_op(4'h8, 9'h100, 1'b0, 1'b0);
        check("neg8xneg256", 32'(acc_out), 32'h0000_0800);
        run_op(4'd7, 9'h1FF, 1'b0, 1'b0);
        check("7xneg1", 32'(acc_out), 32'h0000_FFF9);
        run_op(4'd7, 9'd255, 1'b0, 1'b0);
        check("7x255", 32'(acc_out), 32'd1785);
        run_op(4'd7, 9'd255, 1'b1, 1'b0);
        check("acc_7x255", 32'(acc_out), 32'd3570);
        run_op(4'hF, 9'd1, 1'b1, 1'b0);
        check("acc_neg1x1", 32'(acc_out), 32'd3569);

        for (int i = 0; i < 16; i++)
            run_op(4'h8, 9'h100, (i != 0), 1'b0);
        check("wrap16", 32'(acc_out), 32'h0000_8000);

        run_op(4'd5, 9'h0F3, 1'b0, 1'b1);
        check("spam_ignored", 32'(acc_out), 32'(ACC_W'(5 * 243)));

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        in_x = 4'd3; h = 9'h0AB; acc_en = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_valid", 32'(out_valid), 0);
        check("arst_acc", 32'(acc_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < H_W + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        check("arst_no_valid", nv, 0);
        model_acc = '0;

        // clr during RUN with a simultaneous start.
        run_op(4'd7, 9'd255, 1'b0, 1'b0);
        check("pre_clr", 32'(acc_out), 32'd1785);
        @(negedge clk);
        in_x = 4'd2; h = 9'd3; acc_en = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("clr_busy", 32'(busy), 0);
        check("clr_acc", 32'(acc_out), 0);
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("clr_start_dropped", 32'(busy), 0);
        model_acc = '0;

        // clr beats start in IDLE.
        run_op(4'd7, 9'd255, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b1; start = 1'b1; in_x = 4'd1; h = 9'd1;
        @(posedge clk); #1;
        check("idle_clr_busy", 32'(busy), 0);
        check("idle_clr_acc", 32'(acc_out), 0);
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        model_acc = '0;

        for (int i = 0; i < 40; i++)
            run_op(IN_W'($urandom), H_W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_mac_seq.md
# shift_mac_seq

Sequential, parametrised shift-and-add multiply-accumulate unit. It is the multi-cycle successor to our combinational shift-add multiplier and multiplies a signed sample by a signed two's-complement coefficient. It processes one coefficient bit per clock, so one shared adder replaces the unrolled adder chain. An optional accumulate mode adds each product to the previous result, so one instance can serve as the MAC engine of a time-multiplexed FIR tap loop.

## Interface
- IN_W, 4, sample width (signed), ≥2
- H_W, 9, coefficient width (signed, two's complement), ≥2
- ACC_W, 16, result/accumulator width (signed), ≥ IN_W+H_W
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- acc_en  in  1  sampled with start: 1 = add product to current acc_out, 0 = start from zero
- clr  in  1  synchronous clear/abort
- in_x  in  IN_W  signed sample, sampled with start
- h  in  H_W  signed coefficient, sampled with start
- busy  out  1  high whenever state ≠ IDLE
- out_valid  out  1  one-cycle pulse: acc_out holds a new result
- acc_out  out  ACC_W  signed result, held between operations

## Operation
- States: IDLE, RUN, DONE. busy = (state != IDLE).
- IDLE with start=1 and clr=0:
  - latch h into h_reg.
  - latch in_x sign-extended to ACC_W into x_reg.
  - load partial with acc_out if acc_en=1, else with 0.
  - clear bit counter k to 0.
  - go to RUN.
- RUN, each cycle:
  - if h_reg[k]=1 and k<H_W-1: partial += x_reg.
  - if h_reg[k]=1 and k=H_W-1: partial -= x_reg. The MSB carries weight −2^(H_W-1).
  - then shift x_reg left by 1 (zero fill, ACC_W wide) and increment k.
  - after processing k=H_W-1: copy partial to acc_out, assert out_valid, go to DONE.
- DONE: lasts one cycle, out_valid=1, then go to IDLE. start is ignored in DONE.
- Arithmetic:
  - all adds, subtracts and shifts are modulo 2^ACC_W; no saturation.
  - in accumulate mode, results wrap silently.
  - with acc_en=0 the product always fits, because ACC_W ≥ IN_W+H_W.
- start while busy: ignored, never queued. Operands latched at start are unaffected by later changes on in_x, h or acc_en.
- clr=1, any state: next edge gives state IDLE, acc_out=0, partial=0, out_valid=0, k=0. clr has priority over start in the same cycle.
- acc_out changes only on the DONE transition, on clr, or on reset.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, out_valid=0, acc_out=0, all internal registers 0. Reset mid-RUN discards the operation; no out_valid follows.
- start is sampled at edge E0.
- busy is high from E0 until edge E0+H_W+1.
- RUN covers edges E0+1 … E0+H_W, one bit per edge.
- acc_out updates and out_valid rises at edge E0+H_W. With default H_W=9, the result appears 9 cycles after start is sampled.
- out_valid falls and busy falls at edge E0+H_W+1.
- start is accepted again in the cycle after busy falls. Maximum throughput is one result per H_W+2 cycles.
- Latency is fixed; it does not depend on the value of h, and there is no early termination on zero coefficient bits.

## Test plan
- Default params, x=−3 (4'hD), h=5, acc_en=0 -> out_valid exactly 9 cycles after start, acc_out=16'hFFF1 (−15), busy high for 10 cycles.
- x=−8 (4'h8), h=−256 (9'h100), acc_en=0 -> acc_out=16'h0800 (2048). Checks MSB subtraction and sign extension; repeat with x=7, h=−1 -> 16'hFFF9.
- x=7, h=255, acc_en=0 -> 1785. Then the same operands with acc_en=1 -> 3570. Then x=−1, h=1, acc_en=1 -> 3569.
- Accumulate x=−8, h=−256 sixteen times (first acc_en=0, rest acc_en=1) -> final acc_out=16'h8000. This checks wrap-around with no saturation and no error flag.
- Pulse start with new operands on every cycle of an operation -> ignored. The result equals the original operands' product and exactly one out_valid pulse is seen.
- Deassert rst_n asynchronously at cycle 4 of RUN -> busy, out_valid and acc_out go to 0 immediately, with no out_valid after release. Separately, assert clr in RUN with an acc_out of 1785 -> IDLE next edge, acc_out=0, and a simultaneous start is not accepted.
